// File: rtl/npc_btb_pkg.sv
// Shared control encodings for the fetch-stage next-PC logic: NPC op codes
// and the 2-bit branch predictor counter constants.
package npc_btb_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;

  // Saturating step of a 2-bit predictor counter towards the observed outcome.
  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) begin
      res = cnt + 2'd1;
    end else if (!taken && cnt != 2'b00) begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/npc_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (predict and update
// lookup), one synchronous write port with invalidate, synchronous valid clear.
module npc_btb_table #(
  parameter int WIDTH       = 32,
  parameter int BTB_ENTRIES = 16,
  localparam int IDX        = $clog2(BTB_ENTRIES),
  localparam int TAG_W      = WIDTH - IDX - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   pred_idx,
  output logic             pred_valid,
  output logic [TAG_W-1:0] pred_tag,
  output logic [WIDTH-1:0] pred_target,
  output logic [1:0]       pred_cnt,
  input  logic [IDX-1:0]   upd_idx,
  output logic             upd_valid,
  output logic [TAG_W-1:0] upd_tag,
  output logic [WIDTH-1:0] upd_target,
  output logic [1:0]       upd_cnt,
  input  logic             wr_en,
  input  logic             wr_inv,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [WIDTH-1:0] wr_target,
  input  logic [1:0]       wr_cnt
);

  logic [BTB_ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_mem [BTB_ENTRIES];
  logic [1:0]             cnt_mem    [BTB_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_idx] <= ~wr_inv;
    end
  end

  // Payload needs no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_inv) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
      cnt_mem[wr_idx]    <= wr_cnt;
    end
  end

  assign pred_valid  = valid_reg[pred_idx];
  assign pred_tag    = tag_mem[pred_idx];
  assign pred_target = target_mem[pred_idx];
  assign pred_cnt    = cnt_mem[pred_idx];

  assign upd_valid   = valid_reg[upd_idx];
  assign upd_tag     = tag_mem[upd_idx];
  assign upd_target  = target_mem[upd_idx];
  assign upd_cnt     = cnt_mem[upd_idx];

endmodule

// File: rtl/npc_btb.sv
// Fetch-stage next-PC generator: PC register, BTB-based prediction, ID-stage
// resolution with single-cycle redirect, and BTB training.
module npc_btb
  import npc_btb_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [1:0]       id_npcop,
  input  logic             id_branch,
  input  logic [25:0]      id_instr,
  input  logic [WIDTH-1:0] id_rs,
  output logic             redirect
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pred_next;

  logic             pred_valid, upd_valid;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic [WIDTH-1:0] pred_target, upd_target;
  logic [1:0]       pred_cnt, upd_cnt;
  logic             pred_hit, upd_hit;

  logic             wr_en, wr_inv;
  logic [WIDTH-1:0] wr_target;
  logic [1:0]       wr_cnt;

  npc_op_e          op;
  logic             taken, update;
  logic [WIDTH-1:0] seq_pc, br_target, j_target, target, correct_next;

  npc_btb_table #(
    .WIDTH       (WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .pred_idx    (pc_reg[IDX+1:2]),
    .pred_valid  (pred_valid),
    .pred_tag    (pred_tag),
    .pred_target (pred_target),
    .pred_cnt    (pred_cnt),
    .upd_idx     (id_pc[IDX+1:2]),
    .upd_valid   (upd_valid),
    .upd_tag     (upd_tag),
    .upd_target  (upd_target),
    .upd_cnt     (upd_cnt),
    .wr_en       (wr_en),
    .wr_inv      (wr_inv),
    .wr_idx      (id_pc[IDX+1:2]),
    .wr_tag      (id_pc[WIDTH-1:IDX+2]),
    .wr_target   (wr_target),
    .wr_cnt      (wr_cnt)
  );

  assign pc            = pc_reg;
  assign pred_hit      = pred_valid && (pred_tag == pc_reg[WIDTH-1:IDX+2]);
  assign if_pred_taken = pred_hit && pred_cnt[1];
  assign pred_next     = if_pred_taken ? pred_target : pc_reg + WIDTH'(4);

  assign op        = npc_op_e'(id_npcop);
  assign seq_pc    = id_pc + WIDTH'(4);
  assign br_target = seq_pc + {{(WIDTH-18){id_instr[15]}}, id_instr[15:0], 2'b00};
  assign j_target  = {id_pc[WIDTH-1:28], id_instr, 2'b00};
  assign taken     = (op == NPC_BRANCH && id_branch) || op == NPC_JUMP || op == NPC_JR;

  always_comb begin
    target = seq_pc;
    case (op)
      NPC_BRANCH: target = br_target;
      NPC_JUMP:   target = j_target;
      NPC_JR:     target = id_rs;
      default:    target = seq_pc;
    endcase
  end

  assign correct_next = taken ? target : seq_pc;
  assign update       = id_valid && !stall;
  // IF fetched along the path this ID instruction predicted, so any PC
  // disagreement with the resolved path is a misprediction.
  assign redirect     = update && (pc_reg != correct_next);

  assign upd_hit = upd_valid && (upd_tag == id_pc[WIDTH-1:IDX+2]);

  always_comb begin
    wr_en     = 1'b0;
    wr_inv    = 1'b0;
    wr_target = upd_target;
    wr_cnt    = upd_cnt;
    if (update) begin
      case (op)
        NPC_BRANCH: begin
          if (upd_hit) begin
            wr_en  = 1'b1;
            wr_cnt = cnt_update(upd_cnt, taken);
            if (taken) wr_target = br_target;
          end else if (taken) begin
            wr_en     = 1'b1;
            wr_cnt    = CNT_WT;
            wr_target = br_target;
          end
        end
        NPC_JUMP: begin
          wr_en     = 1'b1;
          wr_cnt    = CNT_ST;
          wr_target = j_target;
        end
        default: begin
          // jr targets are data dependent and sequential ops never branch:
          // drop any entry that hits so it stops steering fetch.
          wr_en  = upd_hit;
          wr_inv = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (!stall) begin
      pc_reg <= redirect ? correct_next : pred_next;
    end
  end

endmodule
